// File: rtl/frame_pkg.sv
// Shared types for the frame capture reader: FSM states,
// FIFO entry sizing and counter helpers.
package frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RECV,
    DRAIN,
    DONE
  } state_e;

  localparam int DEF_DATA_WIDTH = 12;
  localparam int ENTRY_W = DEF_DATA_WIDTH + 1;

  function automatic int entry_w(input int dw);
    return dw + 1;
  endfunction

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v
  );
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/frame_capture_reader_if.sv
// Output stream bundle of the frame capture reader.
// Valid/ready handshake with a last-beat marker.
interface frame_capture_reader_if #(
  parameter int DW = 12
);
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;

  modport master (
    output m_tdata,
    output m_tvalid,
    output m_tlast,
    input  m_tready
  );

  modport slave (
    input  m_tdata,
    input  m_tvalid,
    input  m_tlast,
    output m_tready
  );
endinterface

// File: rtl/sync_stream_fifo.sv
// Single-clock elastic FIFO with registered state.
// mark_last ORs the top bit into the newest stored entry.
module sync_stream_fifo
  import frame_pkg::*;
#(
  parameter int W     = ENTRY_W,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  input  logic                     mark_last,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT =
    (AW+1)'(DEPTH);
  localparam logic [AW-1:0] ONE =
    AW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] last_ptr;
  logic [AW:0]   cnt_q, cnt_d;
  logic          acc;
  logic          deq;

  assign full     = cnt_q == FULL_CNT;
  assign empty    = cnt_q == '0;
  assign count    = cnt_q;
  assign acc      = push & (~full | pop);
  assign deq      = pop & ~empty;
  assign last_ptr = wr_q - ONE;
  assign dout     = empty ? '0 : mem_q[rd_q];

  always_comb begin
    wr_d  = acc ? wr_q + ONE : wr_q;
    rd_d  = deq ? rd_q + ONE : rd_q;
    cnt_d = cnt_q
          + {{AW{1'b0}}, acc}
          - {{AW{1'b0}}, deq};
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      mem_q[wr_q] <= din;
    end else if (mark_last && !empty) begin
      mem_q[last_ptr][W-1] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_capture_reader.sv
// Requests one capture burst, checks its beat count and
// re-emits it as a backpressured stream via an elastic FIFO.
module frame_capture_reader
  import frame_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = 16,
  parameter int REQ_HOLD   = 64,
  parameter int TIMEOUT    = 1048576
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           piont_num,
  output logic                  Request,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  data_vaild,
  input  logic                  data_tlast,
  frame_capture_reader_if.master m_axis,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_overflow,
  output logic                  err_count,
  output logic                  err_timeout
);

  localparam int EW = entry_w(DATA_WIDTH);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] HOLD_LIM =
    32'(REQ_HOLD - 1);
  localparam logic [31:0] TMO_LIM =
    32'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pnum_q, pnum_d;
  logic [31:0] beat_q, beat_d;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] hold_q, hold_d;
  logic        pushed_q, pushed_d;
  logic        mark_q, mark_d;
  logic        req_q, req_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        eovf_q, eovf_d;
  logic        ecnt_q, ecnt_d;
  logic        etmo_q, etmo_d;

  logic          f_push;
  logic [EW-1:0] f_din;
  logic          f_mark;
  logic [EW-1:0] f_dout;
  logic          f_full;
  logic          f_empty;
  logic [AW:0]   f_count;
  logic          f_pop;
  logic          space;
  logic          last_hit;
  logic          tl_eff;
  logic          tmo_hit;

  assign f_pop    = ~f_empty & m_axis.m_tready;
  assign space    = ~f_full | f_pop;
  assign last_hit = ({1'b0, beat_q} + 33'd1)
                 == {1'b0, pnum_q};
  assign tl_eff   = data_tlast | last_hit;
  assign tmo_hit  = tmo_q >= TMO_LIM;

  always_comb begin
    state_d  = state_q;
    pnum_d   = pnum_q;
    beat_d   = beat_q;
    tmo_d    = tmo_q;
    hold_d   = hold_q;
    pushed_d = pushed_q;
    mark_d   = mark_q;
    eovf_d   = eovf_q;
    ecnt_d   = ecnt_q;
    etmo_d   = etmo_q;
    f_push   = 1'b0;
    f_din    = '0;
    f_mark   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && piont_num != 32'd0) begin
          state_d  = REQ;
          pnum_d   = piont_num;
          beat_d   = '0;
          tmo_d    = '0;
          hold_d   = '0;
          pushed_d = 1'b0;
          mark_d   = 1'b0;
          eovf_d   = 1'b0;
          ecnt_d   = 1'b0;
          etmo_d   = 1'b0;
        end
      end
      REQ, RECV: begin
        tmo_d = sat_inc(tmo_q);
        if (state_q == REQ) begin
          hold_d = hold_q + 32'd1;
          if (hold_q >= HOLD_LIM) state_d = RECV;
        end
        // Timeout marker waits for space; beats are dropped meanwhile.
        if (mark_q) begin
          f_push = 1'b1;
          f_din  = {1'b1, {DATA_WIDTH{1'b0}}};
          if (space) begin
            mark_d  = 1'b0;
            state_d = DRAIN;
          end
        end else if (data_vaild) begin
          f_push   = 1'b1;
          f_din    = {tl_eff, rd_data};
          beat_d   = sat_inc(beat_q);
          pushed_d = 1'b1;
          if (!space) begin
            eovf_d = 1'b1;
            f_mark = tl_eff;
          end
          if (tl_eff) begin
            ecnt_d  = ecnt_q
                    | ~(data_tlast & last_hit);
            state_d = DRAIN;
          end else if (tmo_hit) begin
            etmo_d  = 1'b1;
            mark_d  = 1'b1;
            state_d = RECV;
          end
        end else if (tmo_hit) begin
          etmo_d = 1'b1;
          if (pushed_q) begin
            mark_d  = 1'b1;
            state_d = RECV;
          end else begin
            state_d = DONE;
          end
        end
      end
      DRAIN: begin
        if (f_count == '0) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    req_d  = state_d == REQ;
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pnum_q   <= '0;
      beat_q   <= '0;
      tmo_q    <= '0;
      hold_q   <= '0;
      pushed_q <= 1'b0;
      mark_q   <= 1'b0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      eovf_q   <= 1'b0;
      ecnt_q   <= 1'b0;
      etmo_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pnum_q   <= pnum_d;
      beat_q   <= beat_d;
      tmo_q    <= tmo_d;
      hold_q   <= hold_d;
      pushed_q <= pushed_d;
      mark_q   <= mark_d;
      req_q    <= req_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      eovf_q   <= eovf_d;
      ecnt_q   <= ecnt_d;
      etmo_q   <= etmo_d;
    end
  end

  sync_stream_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (rd_clk),
    .rst_n     (rst_n),
    .push      (f_push),
    .din       (f_din),
    .pop       (f_pop),
    .mark_last (f_mark),
    .dout      (f_dout),
    .full      (f_full),
    .empty     (f_empty),
    .count     (f_count)
  );

  assign m_axis.m_tvalid = ~f_empty;
  assign m_axis.m_tdata  = f_dout[DATA_WIDTH-1:0];
  assign m_axis.m_tlast  = f_dout[EW-1];

  assign Request      = req_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign err_overflow = eovf_q;
  assign err_count    = ecnt_q;
  assign err_timeout  = etmo_q;

endmodule

// File: tb/tb_frame_capture_reader.sv
// Randomized self-checking bench for frame_capture_reader
// against a queue-based frame model.
module tb_frame_capture_reader;

  localparam int DW    = 12;
  localparam int DEPTH = 16;
  localparam int HOLD  = 64;
  localparam int TMO   = 1000;
  localparam int MAXC  = 4000;

  logic          rd_clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   piont_num = '0;
  logic          Request;
  logic [DW-1:0] rd_data = '0;
  logic          data_vaild = 1'b0;
  logic          data_tlast = 1'b0;
  logic          busy;
  logic          frame_done;
  logic          err_overflow;
  logic          err_count;
  logic          err_timeout;

  frame_capture_reader_if #(.DW(DW)) s_if ();

  frame_capture_reader #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .REQ_HOLD   (HOLD),
    .TIMEOUT    (TMO)
  ) dut (
    .rd_clk       (rd_clk),
    .rst_n        (rst_n),
    .start        (start),
    .piont_num    (piont_num),
    .Request      (Request),
    .rd_data      (rd_data),
    .data_vaild   (data_vaild),
    .data_tlast   (data_tlast),
    .m_axis       (s_if),
    .busy         (busy),
    .frame_done   (frame_done),
    .err_overflow (err_overflow),
    .err_count    (err_count),
    .err_timeout  (err_timeout)
  );

  always #5 rd_clk = ~rd_clk;

  int compared = 0;
  int mismatched = 0;

  logic [DW-1:0] src_data [64];
  logic [DW:0]   got_q [$];
  logic [DW:0]   exp_q [$];
  logic          exp_ecnt;
  logic          exp_ovf;
  int  req_hi, done_cnt, first_req, first_tmo, cyc;
  bit  saw_valid, src_done, mon_done;

  // Frame model: the burst ends at the source tlast or at beat pn,
  // whichever is first; only the first cap beats survive a stall.
  task automatic model_frame(input int pn, input int tl,
                             input int cap);
    int last_i, kept;
    last_i = (tl != 0 && tl <= pn) ? tl : pn;
    kept = (last_i < cap) ? last_i : cap;
    exp_ecnt = (tl != pn);
    exp_ovf = (last_i > cap);
    exp_q.delete();
    for (int i = 0; i < kept; i++)
      exp_q.push_back({(i == kept - 1), src_data[i]});
  endtask

  task automatic do_frame(input int pn, input int nb,
                          input int tl, input int mode);
    got_q.delete();
    req_hi = 0; done_cnt = 0; cyc = 0;
    first_req = -1; first_tmo = -1;
    saw_valid = 0; src_done = 0; mon_done = 0;
    s_if.m_tready = (mode == 0);
    @(posedge rd_clk); #1;
    piont_num = pn; start = 1'b1;
    @(posedge rd_clk); #1;
    start = 1'b0;
    fork
      begin : src
        bit seen;
        seen = 0;
        for (int i = 0; i < HOLD * 4; i++) begin
          if (Request) seen = 1;
          else if (seen) break;
          @(posedge rd_clk); #1;
        end
        for (int i = 0; i < nb; i++) begin
          data_vaild = 1'b1;
          rd_data = src_data[i];
          data_tlast = (i + 1 == tl);
          @(posedge rd_clk); #1;
        end
        data_vaild = 1'b0;
        data_tlast = 1'b0;
        src_done = 1;
      end
      begin : rdy
        while (!mon_done) begin
          if (mode == 1) s_if.m_tready = src_done;
          else if (mode == 2)
            s_if.m_tready = ($urandom_range(3) != 0);
          else s_if.m_tready = 1'b1;
          @(posedge rd_clk); #1;
        end
      end
      begin : mon
        int extra;
        extra = -1;
        for (int c = 0; c < MAXC && extra != 0; c++) begin
          @(negedge rd_clk);
          cyc++;
          if (Request) req_hi++;
          if (Request && first_req < 0) first_req = cyc;
          if (err_timeout && first_tmo < 0) first_tmo = cyc;
          if (s_if.m_tvalid) saw_valid = 1;
          if (s_if.m_tvalid && s_if.m_tready)
            got_q.push_back({s_if.m_tlast, s_if.m_tdata});
          if (frame_done) begin
            done_cnt++;
            if (extra < 0) extra = 6;
          end
          if (extra > 0) extra--;
        end
        if (done_cnt == 0) begin
          compared++; mismatched++;
          $display("FAIL frame_wait: no frame_done in %0d cycles",
                   MAXC);
        end
        mon_done = 1;
      end
    join
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    repeat (3) @(negedge rd_clk);
    compared++;
    if ({Request, busy, frame_done, err_overflow, err_count,
         err_timeout, s_if.m_tvalid, s_if.m_tlast} !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_flags: got %b, need 00000000",
               {Request, busy, frame_done, err_overflow, err_count,
                err_timeout, s_if.m_tvalid, s_if.m_tlast});
    end
    compared++;
    if (s_if.m_tdata !== '0) begin
      mismatched++;
      $display("FAIL reset_tdata: got %h, need 0", s_if.m_tdata);
    end
    @(posedge rd_clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_ignored();
    bit bad;
    bad = 0;
    @(posedge rd_clk); #1;
    piont_num = 0; start = 1'b1;
    data_vaild = 1'b1; data_tlast = 1'b1; rd_data = 12'h5a5;
    @(posedge rd_clk); #1;
    start = 1'b0; data_vaild = 1'b0; data_tlast = 1'b0;
    repeat (6) begin
      @(negedge rd_clk);
      if (busy || Request || s_if.m_tvalid) bad = 1;
    end
    compared++;
    if (bad) begin
      mismatched++;
      $display("FAIL ignored_start: got activity, need idle");
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 8; i++) src_data[i] = DW'(i + 1);
    model_frame(8, 8, 1000);
    do_frame(8, 8, 8, 0);
    compared++;
    if (got_q.size() !== exp_q.size()) begin
      mismatched++;
      $display("FAIL t1_len: got %0d, need %0d",
               got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      compared++;
      if (got_q[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL t1_beat%0d: got %h, need %h",
                 i, got_q[i], exp_q[i]);
      end
    end
    compared++;
    if (done_cnt !== 1) begin
      mismatched++;
      $display("FAIL t1_done: got %0d, need 1", done_cnt);
    end
    compared++;
    if ({err_overflow, err_count, err_timeout} !== 3'b000) begin
      mismatched++;
      $display("FAIL t1_err: got %b, need 000",
               {err_overflow, err_count, err_timeout});
    end
    compared++;
    if (req_hi !== HOLD) begin
      mismatched++;
      $display("FAIL t1_req_hold: got %0d, need %0d", req_hi, HOLD);
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL t1_busy: got %b, need 0", busy);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) src_data[i] = DW'($urandom);
    model_frame(8, 8, DEPTH);
    do_frame(8, 8, 8, 1);
    compared++;
    if (got_q.size() !== exp_q.size()) begin
      mismatched++;
      $display("FAIL t2_len: got %0d, need %0d",
               got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      compared++;
      if (got_q[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL t2_beat%0d: got %h, need %h",
                 i, got_q[i], exp_q[i]);
      end
    end
    compared++;
    if (err_overflow !== exp_ovf) begin
      mismatched++;
      $display("FAIL t2_ovf: got %b, need %b", err_overflow, exp_ovf);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 20; i++) src_data[i] = DW'($urandom);
    model_frame(20, 20, DEPTH);
    do_frame(20, 20, 20, 1);
    compared++;
    if (got_q.size() !== exp_q.size()) begin
      mismatched++;
      $display("FAIL t3_len: got %0d, need %0d",
               got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      compared++;
      if (got_q[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL t3_beat%0d: got %h, need %h",
                 i, got_q[i], exp_q[i]);
      end
    end
    compared++;
    if ({err_overflow, err_count} !== {exp_ovf, exp_ecnt}) begin
      mismatched++;
      $display("FAIL t3_err: got %b, need %b",
               {err_overflow, err_count}, {exp_ovf, exp_ecnt});
    end
    compared++;
    if (done_cnt !== 1) begin
      mismatched++;
      $display("FAIL t3_done: got %0d, need 1", done_cnt);
    end
  endtask

  task automatic test_short();
    for (int i = 0; i < 5; i++) src_data[i] = DW'($urandom);
    model_frame(5, 3, 1000);
    do_frame(5, 3, 3, 0);
    compared++;
    if (got_q.size() !== exp_q.size()) begin
      mismatched++;
      $display("FAIL t4_len: got %0d, need %0d",
               got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      compared++;
      if (got_q[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL t4_beat%0d: got %h, need %h",
                 i, got_q[i], exp_q[i]);
      end
    end
    compared++;
    if (err_count !== exp_ecnt) begin
      mismatched++;
      $display("FAIL t4_ecnt: got %b, need %b", err_count, exp_ecnt);
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL t4_idle: got busy %b, need 0", busy);
    end
  endtask

  task automatic test_timeout();
    do_frame(8, 0, 0, 0);
    compared++;
    if (err_timeout !== 1'b1) begin
      mismatched++;
      $display("FAIL t5_flag: got %b, need 1", err_timeout);
    end
    compared++;
    if (first_tmo - first_req !== TMO) begin
      mismatched++;
      $display("FAIL t5_time: got %0d, need %0d",
               first_tmo - first_req, TMO);
    end
    compared++;
    if (saw_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL t5_tvalid: got %b, need 0", saw_valid);
    end
    compared++;
    if (done_cnt !== 1) begin
      mismatched++;
      $display("FAIL t5_done: got %0d, need 1", done_cnt);
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    seen = 0;
    for (int i = 0; i < 8; i++) src_data[i] = DW'(i + 1);
    s_if.m_tready = 1'b0;
    @(posedge rd_clk); #1;
    piont_num = 8; start = 1'b1;
    @(posedge rd_clk); #1;
    start = 1'b0;
    for (int i = 0; i < HOLD * 4; i++) begin
      if (Request) seen = 1;
      else if (seen) break;
      @(posedge rd_clk); #1;
    end
    for (int i = 0; i < 4; i++) begin
      data_vaild = 1'b1; rd_data = src_data[i];
      @(posedge rd_clk); #1;
    end
    data_vaild = 1'b0;
    @(negedge rd_clk);
    compared++;
    if ({busy, s_if.m_tvalid} !== 2'b11) begin
      mismatched++;
      $display("FAIL t6_pre: got %b, need 11",
               {busy, s_if.m_tvalid});
    end
    @(posedge rd_clk); #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({Request, busy, frame_done, err_overflow, err_count,
         err_timeout, s_if.m_tvalid, s_if.m_tlast} !== 8'h00 ||
        s_if.m_tdata !== '0) begin
      mismatched++;
      $display("FAIL t6_async: got %b/%h, need 0/0",
               {Request, busy, frame_done, err_overflow, err_count,
                err_timeout, s_if.m_tvalid, s_if.m_tlast},
               s_if.m_tdata);
    end
    @(posedge rd_clk); #2;
    rst_n = 1'b1;
    test_basic();
  endtask

  task automatic test_random();
    int pn, tl, nb, pick, last_i;
    for (int f = 0; f < 6; f++) begin
      pn = $urandom_range(12, 1);
      pick = $urandom_range(2);
      tl = (pick == 0) ? pn :
           (pick == 1) ? $urandom_range(pn, 1) : 0;
      last_i = (tl != 0) ? tl : pn;
      nb = last_i + $urandom_range(2);
      for (int i = 0; i < nb; i++) src_data[i] = DW'($urandom);
      model_frame(pn, tl, 1000);
      do_frame(pn, nb, tl, 2);
      compared++;
      if (got_q.size() !== exp_q.size()) begin
        mismatched++;
        $display("FAIL rnd%0d_len: got %0d, need %0d",
                 f, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        compared++;
        if (got_q[i] !== exp_q[i]) begin
          mismatched++;
          $display("FAIL rnd%0d_beat%0d: got %h, need %h",
                   f, i, got_q[i], exp_q[i]);
        end
      end
      compared++;
      if ({err_overflow, err_count, err_timeout}
          !== {1'b0, exp_ecnt, 1'b0}) begin
        mismatched++;
        $display("FAIL rnd%0d_err: got %b, need %b", f,
                 {err_overflow, err_count, err_timeout},
                 {1'b0, exp_ecnt, 1'b0});
      end
    end
  endtask

  initial begin
    s_if.m_tready = 1'b0;
    test_reset();
    test_ignored();
    test_basic();
    test_backpressure();
    test_overflow();
    test_short();
    test_timeout();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
